// File: rtl/conv33_window_gen_if.sv
// conv33_window_gen_if: pixel-in / window-out handshake bundle for conv33_window_gen.
interface conv33_window_gen_if #(
  parameter int DATA_W = 8
);
  logic                start;
  logic                done;
  logic [DATA_W-1:0]   pix_in;
  logic                valid_in;
  logic                ready_out;
  logic [9*DATA_W-1:0] win_out;
  logic                valid_out;
  logic                ready_in;
  modport master (output start, pix_in, valid_in, ready_in, input done, ready_out, win_out, valid_out);
  modport slave (input start, pix_in, valid_in, ready_in, output done, ready_out, win_out, valid_out);
endinterface

// File: rtl/conv33_window_gen.sv
// conv33_window_gen: 3x3 sliding-window builder over a raster pixel stream using two line buffers.
// Optional macro CONV33_WIN_STRIDE2_EN: emit only windows with even (r-2),(c-2) (stride 2).
module conv33_window_gen #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
) (
  input logic               clk,
  input logic               rst,
  conv33_window_gen_if.slave bus
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2;
  logic [1:0]              state_q, state_d;
  logic [CW-1:0]           col_q, col_d;
  logic [RW-1:0]           row_q, row_d;
  logic [8:0][DATA_W-1:0]  sh_q, sh_d, win_q, win_d;
  logic                    valid_q, valid_d, done_q, done_d;
  logic [DATA_W-1:0]       lb0_q [IMG_W];
  logic [DATA_W-1:0]       lb1_q [IMG_W];
  logic                    go, acc, emit, xfer, last_col, last;
  assign bus.ready_out = (state_q == RUN) && (!valid_q || bus.ready_in);
  assign bus.valid_out = valid_q;
  assign bus.win_out   = win_q;
  assign bus.done      = done_q;
  assign go       = (state_q == IDLE) && bus.start;
  assign acc      = bus.valid_in && bus.ready_out;
  assign xfer     = valid_q && bus.ready_in;
  assign last_col = col_q == CW'(IMG_W - 1);
  assign last     = acc && last_col && (row_q == RW'(IMG_H - 1));
`ifdef CONV33_WIN_STRIDE2_EN
  assign emit = acc && (row_q >= RW'(2)) && (col_q >= CW'(2)) && !row_q[0] && !col_q[0];
`else
  assign emit = acc && (row_q >= RW'(2)) && (col_q >= CW'(2));
`endif
  // The shifted window is also the emitted one, so the output register captures sh_d directly.
  always_comb begin
    sh_d = sh_q;
    for (int i = 0; i < 3; i++) begin
      sh_d[i*3]   = sh_q[i*3+1];
      sh_d[i*3+1] = sh_q[i*3+2];
    end
    sh_d[2] = lb1_q[col_q];
    sh_d[5] = lb0_q[col_q];
    sh_d[8] = bus.pix_in;
    win_d   = emit ? sh_d : win_q;
    valid_d = emit || (valid_q && !bus.ready_in);
    done_d  = (last && !emit) || (state_q == FLUSH && xfer);
    col_d   = go ? '0 : acc ? (last_col ? '0 : col_q + 1'b1) : col_q;
    row_d   = go ? '0 : (acc && last_col) ? row_q + 1'b1 : row_q;
    state_d = go ? RUN : last ? (emit ? FLUSH : IDLE) : (state_q == FLUSH && xfer) ? IDLE : state_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      sh_q    <= '0;
      win_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      sh_q    <= acc ? sh_d : sh_q;
      win_q   <= win_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  always_ff @(posedge clk)
    if (acc) begin
      lb1_q[col_q] <= lb0_q[col_q];
      lb0_q[col_q] <= bus.pix_in;
    end
endmodule

// File: tb/tb_conv33_window_gen.sv
// tb_conv33_window_gen: scoreboard bench for conv33_window_gen on a 5x5 frame.
module tb_conv33_window_gen;
  localparam int W = 5;
`ifdef CONV33_WIN_STRIDE2_EN
  localparam int NWIN = 4;
`else
  localparam int NWIN = 9;
`endif
  localparam logic [71:0] FIRST_WIN = {8'd12, 8'd11, 8'd10, 8'd7, 8'd6, 8'd5, 8'd2, 8'd1, 8'd0};
  localparam logic [71:0] LAST_WIN  = {8'd24, 8'd23, 8'd22, 8'd19, 8'd18, 8'd17, 8'd14, 8'd13, 8'd12};
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int win_cnt = 0;
  logic [71:0] first_win, last_win;
  logic [71:0] exp_q [$];
  conv33_window_gen_if #(.DATA_W(8)) bus ();
  conv33_window_gen #(.DATA_W(8), .IMG_W(W), .IMG_H(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask
  function automatic logic [7:0] pv(input int off, input int x);
    return 8'(off + x);
  endfunction
  function automatic bit is_win(input int p);
    int r, c;
    r = p / W;
    c = p % W;
`ifdef CONV33_WIN_STRIDE2_EN
    return r >= 2 && c >= 2 && r % 2 == 0 && c % 2 == 0;
`else
    return r >= 2 && c >= 2;
`endif
  endfunction
  function automatic logic [71:0] win_of(input int off, input int p);
    logic [71:0] w;
    int r, c;
    r = p / W;
    c = p % W;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[(i*3+j)*8 +: 8] = pv(off, (r - 2 + i) * W + c - 2 + j);
    return w;
  endfunction
  // Monitor: pops the scoreboard on every transfer and polices hold/done behaviour.
  logic hold = 1'b0, prev_x = 1'b0;
  logic [71:0] hold_win;
  always @(negedge clk) begin
    if (rst) begin
      hold = 1'b0;
      prev_x = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_valid", 72'(bus.valid_out), 72'd1);
        chk("hold_win", bus.win_out, hold_win);
      end
      if (bus.done) begin
        chk("done_after_xfer", 72'(prev_x), 72'd1);
        chk("done_queue_empty", 72'(exp_q.size()), 72'd0);
      end
      if (bus.valid_out && bus.ready_in) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_window: got %h expected none", bus.win_out);
        end else begin
          chk("window", bus.win_out, exp_q.pop_front());
          if (win_cnt == 0) first_win = bus.win_out;
          last_win = bus.win_out;
          win_cnt++;
        end
      end
      hold = bus.valid_out && !bus.ready_in;
      hold_win = bus.win_out;
      prev_x = bus.valid_out && bus.ready_in;
    end
  end
  task automatic send_frame(input int off, input int stall_idx, input int rst_idx, input int start_idx);
    int n;
    bit pe;
    pe = 0;
    win_cnt = 0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int p = 0; p < W * W; p++) begin
      bus.pix_in = pv(off, p);
      bus.valid_in = 1'b1;
      @(negedge clk);
      if (p > 0) chk("emit_latency", 72'(bus.valid_out), 72'(pe));
      n = 0;
      while (!bus.ready_out && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (!bus.ready_out) begin
        chk("accept_timeout", 72'(bus.ready_out), 72'd1);
        bus.valid_in = 1'b0;
        return;
      end
      pe = is_win(p);
      if (pe) exp_q.push_back(win_of(off, p));
      bus.start = (p == start_idx);
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (p == rst_idx) begin
        rst = 1'b1;
        bus.valid_in = 1'b0;
        #1;
        chk("rst_valid_out", 72'(bus.valid_out), 72'd0);
        chk("rst_done", 72'(bus.done), 72'd0);
        chk("rst_ready_out", 72'(bus.ready_out), 72'd0);
        chk("rst_win_out", bus.win_out, 72'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      if (p == stall_idx) begin
        bus.ready_in = 1'b0;
        bus.pix_in = pv(off, p + 1);
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("stall_ready_out", 72'(bus.ready_out), 72'd0);
          chk("stall_valid_out", 72'(bus.valid_out), 72'd1);
        end
        @(posedge clk); #1;
        bus.ready_in = 1'b1;
      end
    end
    bus.valid_in = 1'b0;
    @(negedge clk);
    chk("emit_latency", 72'(bus.valid_out), 72'(pe));
    n = 0;
    while (!bus.done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 72'(bus.done), 72'd1);
    @(negedge clk);
    chk("done_one_cycle", 72'(bus.done), 72'd0);
    chk("window_count", 72'(win_cnt), 72'(NWIN));
  endtask
  initial begin
    bus.start = 1'b0;
    bus.pix_in = '0;
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b1;
    @(negedge clk);
    chk("reset_valid_out", 72'(bus.valid_out), 72'd0);
    chk("reset_done", 72'(bus.done), 72'd0);
    chk("reset_ready_out", 72'(bus.ready_out), 72'd0);
    chk("reset_win_out", bus.win_out, 72'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.valid_in = 1'b1;
    bus.pix_in = 8'd99;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("idle_ready_out", 72'(bus.ready_out), 72'd0);
      chk("idle_valid_out", 72'(bus.valid_out), 72'd0);
    end
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
    send_frame(0, -1, -1, -1);
    chk("first_window", first_win, FIRST_WIN);
    chk("last_window", last_win, LAST_WIN);
    send_frame(40, 12, -1, -1);
    send_frame(80, -1, 12, -1);
    send_frame(120, -1, -1, 7);
    repeat (3) @(posedge clk);
    chk("leftover_expected", 72'(exp_q.size()), 72'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv33_window_gen.md
Name: conv33_window_gen

Overview:
- Upstream neighbour of the conv33 input control stage.
- Accepts a raster-order pixel stream for one feature-map frame and builds 3x3 sliding windows using two internal line buffers.
- Presents each window as one 9-pixel word to the conv33 engine with valid/ready handshaking.
- Valid convolution only (no padding): one window per pixel at row>=2 and col>=2.

Parameters:
- DATA_W, 8, pixel width in bits
- IMG_W, 28, frame width in pixels (>=3)
- IMG_H, 28, frame height in pixels (>=3)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous active-high reset
- start  input  1  one-cycle pulse, begins a frame; ignored unless IDLE
- done  output  1  one-cycle pulse, frame fully consumed and last window delivered
- pix_in  input  DATA_W  input pixel
- valid_in  input  1  pix_in valid
- ready_out  output  1  block can accept pix_in this cycle
- win_out  output  9*DATA_W  window; slot k=i*3+j at bits [k*DATA_W +: DATA_W], i=row (0=top), j=col (0=left)
- valid_out  output  1  win_out valid
- ready_in  input  1  downstream accepts win_out

Behaviour:
- Reset values: done=0, valid_out=0, win_out=0, ready_out=0, state=IDLE, row/col counters=0. Line-buffer RAM contents are not cleared.
- States:
  - IDLE: start -> RUN, clearing the counters.
  - RUN: accepts pixels.
  - FLUSH: all pixels consumed, a window is still pending.
  - Exit from RUN/FLUSH -> IDLE with a done pulse, per the done rule below.
- ready_out = (state==RUN) && (!valid_out || ready_in). Combinational on ready_in, no other input dependency.
- Accept = valid_in && ready_out. On accept of pixel (r,c):
  - Shift the 3x3 register window left one column; the new right column is {linebuf1[c], linebuf0[c], pix_in} (top to bottom).
  - Write linebuf1[c] <= linebuf0[c] and linebuf0[c] <= pix_in.
  - Advance col; col wraps at IMG_W-1 to 0 and increments row.
- Window emit:
  - If the accepted pixel has r>=2 and c>=2, valid_out=1 on the next cycle (latency 1) with the window whose bottom-right is (r,c).
  - Columns from the previous row are never mixed in: window validity requires c>=2 in the current row.
- Output hold:
  - win_out and valid_out are held stable while valid_out && !ready_in.
  - valid_out drops the cycle after a transfer unless a new window is produced in the same cycle.
- Back-pressure: when valid_out && !ready_in, ready_out=0 and no pixel is taken. Every window is delivered exactly once, no loss and no duplication.
- Frame end: after pixel (IMG_H-1, IMG_W-1) is accepted, go to FLUSH if a window is pending, else to IDLE.
- done rule: done pulses for one cycle, the cycle after the final window transfer (or the cycle after the last accept when nothing is pending).
- Window count per frame: (IMG_W-2)*(IMG_H-2).
- start while not IDLE: ignored.
- valid_in while IDLE/FLUSH: ignored, since ready_out=0.
- Reset mid-frame: immediate return to IDLE. All outputs take reset values; the partial frame is discarded.

Optional Feature:
- Macro: CONV33_WIN_STRIDE2_EN.
- Defined: a window is emitted only when (r-2) and (c-2) are both even (stride 2). All pixels are still consumed, and line buffers update on every accept. Per-frame count is floor((IMG_W-1)/2)*floor((IMG_H-1)/2) (13x13=169 at defaults). done follows the same rule; with IMG odd the last window coincides with the last pixel.
- Undefined: stride 1 as described above.

Test Plan:
- IMG_W=IMG_H=5, ready_in=1, pixels p=r*5+c streamed back-to-back -> first valid_out one cycle after accepting p=12, with win_out slots 0..8 = 0,1,2,5,6,7,10,11,12. Exactly 9 windows in total; last window = 12,13,14,17,18,19,22,23,24. done pulses once, the cycle after the last window.
- Same stream with ready_in low for 3 cycles while the first window is pending -> ready_out=0 for those cycles, win_out stable at the first window, no window dropped. Total still 9 windows, order preserved.
- Row-boundary check, 5x5: accepts at (3,0) and (3,1) -> no valid_out; first row-3 window comes at (3,2) = 5,6,7,10,11,12,15,16,17.
- Assert rst for one cycle after 13 pixels accepted -> valid_out, done and ready_out go to 0 immediately. A new start plus a full 5x5 frame then yields exactly 9 correct windows.
- start pulsed during RUN -> no counter reset, frame output unchanged. valid_in pulsed in IDLE -> ignored, no valid_out.
- CONV33_WIN_STRIDE2_EN defined, 5x5 -> exactly 4 windows, with bottom-right at (2,2),(2,4),(4,2),(4,4). The (4,4) window = 12,13,14,17,18,19,22,23,24. done pulses after it.
